// File: rtl/truth_table_scanner.sv
// Exhaustive scanner for a 3-input combinational truth table: drives each of the
// eight input vectors, waits for it to settle, and compares r against a captured reference.
module truth_table_scanner #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] ref_table,
  input  logic       r,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] mismatch_mask,
  output logic [3:0] mismatch_cnt,
  output logic       err_valid,
  output logic [2:0] err_vec,
  output logic       err_exp,
  output logic       err_got,
  output logic [1:0] state
);

  // Handshake: start is a level sampled only in IDLE; done and err_valid are
  // single-cycle pulses with no back-pressure, and err_* payload holds until the next error.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(SETTLE_CYCLES - 1);

  state_t     st;
  logic [2:0] idx;
  logic [3:0] wait_cnt;
  logic [7:0] ref_q;
  logic       miss;

  assign miss  = (r != ref_q[idx]);
  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      idx           <= 3'd0;
      wait_cnt      <= 4'd0;
      ref_q         <= 8'd0;
      {a, b, c}     <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch_mask <= 8'd0;
      mismatch_cnt  <= 4'd0;
      err_valid     <= 1'b0;
      err_vec       <= 3'd0;
      err_exp       <= 1'b0;
      err_got       <= 1'b0;
    end else begin
      done      <= 1'b0;
      err_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            ref_q         <= ref_table;
            mismatch_mask <= 8'd0;
            mismatch_cnt  <= 4'd0;
            idx           <= 3'd0;
            wait_cnt      <= 4'd0;
            {a, b, c}     <= 3'd0;
            busy          <= 1'b1;
            st            <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            {a, b, c} <= 3'd0;
            busy      <= 1'b0;
            st        <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt == LAST_WAIT) st <= CHECK;
          end
        end
        CHECK: begin
          // Abort suppresses the comparison made in this same cycle.
          if (abort) begin
            {a, b, c} <= 3'd0;
            busy      <= 1'b0;
            st        <= IDLE;
          end else begin
            if (miss) begin
              mismatch_mask[idx] <= 1'b1;
              mismatch_cnt       <= mismatch_cnt + 4'd1;
              err_valid          <= 1'b1;
              err_vec            <= idx;
              err_exp            <= ref_q[idx];
              err_got            <= r;
            end
            if (idx != 3'd7) begin
              idx       <= idx + 3'd1;
              wait_cnt  <= 4'd0;
              {a, b, c} <= idx + 3'd1;
              st        <= SETTLE;
            end else begin
              {a, b, c} <= 3'd0;
              busy      <= 1'b0;
              st        <= DONE;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
